// File: rtl/timer_core.sv
// timer_core: dual CNT_W-bit timer/counter datapath.
// Each counter loads on an enable rising edge, then steps up or down on its
// tick, and on a compare hit either reloads or keeps stepping, emitting a
// one-cycle registered match pulse. Counter1 ticks every clock or only on
// counter0 match events (cascade mode).
// Optional feature macro: TIMER_CORE_IRQ_EN adds sticky per-counter status
// bits with a registered interrupt output.
module timer_core #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cnt0_en,
  input  logic             i_cnt0_reload,
  input  logic             i_cnt0_count_up,
  input  logic [CNT_W-1:0] i_cnt0_load_value,
  input  logic [CNT_W-1:0] i_cnt0_compare_value,
  input  logic             i_cnt1_en,
  input  logic             i_cnt1_reload,
  input  logic             i_cnt1_count_up,
  input  logic             i_cnt1_src,
  input  logic [CNT_W-1:0] i_cnt1_load_value,
  input  logic [CNT_W-1:0] i_cnt1_compare_value,
  output logic [CNT_W-1:0] o_cnt0_value,
  output logic             o_cnt0_match,
  output logic [CNT_W-1:0] o_cnt1_value,
  output logic             o_cnt1_match
`ifdef TIMER_CORE_IRQ_EN
  ,
  input  logic [1:0]       i_irq_clr,
  output logic [1:0]       o_irq_status,
  output logic             o_irq
`endif
);

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_LOAD,
    MODE_RUN
  } mode_e;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             en0_d, en1_d;
  mode_e            mode0, mode1;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic [CNT_W-1:0] cnt0_nxt, cnt1_nxt;
  logic             match0_q, match1_q;
  logic             match0_evt, match1_evt;
  logic             tick1;

  // Enable history: the per-counter mode state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      en0_d <= 1'b0;
      en1_d <= 1'b0;
    end else begin
      en0_d <= i_cnt0_en;
      en1_d <= i_cnt1_en;
    end
  end

  // Mode decode: idle when disabled, load on enable rising edge, else run.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    mode0 = MODE_IDLE;
    mode1 = MODE_IDLE;
    if (i_cnt0_en) mode0 = en0_d ? MODE_RUN : MODE_LOAD;
    if (i_cnt1_en) mode1 = en1_d ? MODE_RUN : MODE_LOAD;
  end

  // Tick, match-event and next-count evaluation for both counters.
  always_comb begin
    match0_evt = (mode0 == MODE_RUN) && (cnt0_q == i_cnt0_compare_value);
    tick1      = i_cnt1_src ? match0_evt : 1'b1;
    match1_evt = (mode1 == MODE_RUN) && tick1 && (cnt1_q == i_cnt1_compare_value);

    cnt0_nxt = cnt0_q;
    case (mode0)
      MODE_LOAD: cnt0_nxt = i_cnt0_load_value;
      MODE_RUN: begin
        if (match0_evt && i_cnt0_reload) cnt0_nxt = i_cnt0_load_value;
        else if (i_cnt0_count_up)        cnt0_nxt = cnt0_q + ONE;
        else                             cnt0_nxt = cnt0_q - ONE;
      end
      default: cnt0_nxt = cnt0_q;
    endcase

    cnt1_nxt = cnt1_q;
    case (mode1)
      MODE_LOAD: cnt1_nxt = i_cnt1_load_value;
      MODE_RUN: begin
        if (!tick1)                           cnt1_nxt = cnt1_q;
        else if (match1_evt && i_cnt1_reload) cnt1_nxt = i_cnt1_load_value;
        else if (i_cnt1_count_up)             cnt1_nxt = cnt1_q + ONE;
        else                                  cnt1_nxt = cnt1_q - ONE;
      end
      default: cnt1_nxt = cnt1_q;
    endcase
  end

  // Counter values and registered one-cycle match pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      match0_q <= 1'b0;
      match1_q <= 1'b0;
    end else begin
      cnt0_q   <= cnt0_nxt;
      cnt1_q   <= cnt1_nxt;
      match0_q <= match0_evt;
      match1_q <= match1_evt;
    end
  end

  // Output drive from the registered state.
  always_comb begin
    o_cnt0_value = cnt0_q;
    o_cnt0_match = match0_q;
    o_cnt1_value = cnt1_q;
    o_cnt1_match = match1_q;
  end

`ifdef TIMER_CORE_IRQ_EN
  logic [1:0] irq_status_q;
  logic       irq_q;

  // Sticky status set by match pulses (set beats clear); irq follows a cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_status_q <= 2'b00;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= {match1_q, match0_q} | (irq_status_q & ~i_irq_clr);
      irq_q        <= |irq_status_q;
    end
  end

  // Interrupt output drive.
  always_comb begin
    o_irq_status = irq_status_q;
    o_irq        = irq_q;
  end
`endif

endmodule

// File: tb/tb_timer_core.sv
// Randomized + directed bench for timer_core. Stimulus is driven on the
// falling edge; a behavioural model predicts the post-edge outputs and
// queues them; a monitor pops and compares just after each rising edge.
module tb_timer_core;

  logic        clk;
  logic        rst_n;
  logic        cnt0_en, cnt0_reload, cnt0_count_up;
  logic [31:0] cnt0_load, cnt0_cmp;
  logic        cnt1_en, cnt1_reload, cnt1_count_up, cnt1_src;
  logic [31:0] cnt1_load, cnt1_cmp;
  logic [31:0] cnt0_value, cnt1_value;
  logic        cnt0_match, cnt1_match;
  logic [1:0]  irq_clr;
`ifdef TIMER_CORE_IRQ_EN
  logic [1:0]  irq_status;
  logic        irq;
`endif

  timer_core #(.CNT_W(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_cnt0_en            (cnt0_en),
    .i_cnt0_reload        (cnt0_reload),
    .i_cnt0_count_up      (cnt0_count_up),
    .i_cnt0_load_value    (cnt0_load),
    .i_cnt0_compare_value (cnt0_cmp),
    .i_cnt1_en            (cnt1_en),
    .i_cnt1_reload        (cnt1_reload),
    .i_cnt1_count_up      (cnt1_count_up),
    .i_cnt1_src           (cnt1_src),
    .i_cnt1_load_value    (cnt1_load),
    .i_cnt1_compare_value (cnt1_cmp),
    .o_cnt0_value         (cnt0_value),
    .o_cnt0_match         (cnt0_match),
    .o_cnt1_value         (cnt1_value),
    .o_cnt1_match         (cnt1_match)
`ifdef TIMER_CORE_IRQ_EN
    ,
    .i_irq_clr            (irq_clr),
    .o_irq_status         (irq_status),
    .o_irq                (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v0;
    logic        m0;
    logic [31:0] v1;
    logic        m1;
    logic [1:0]  st;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: what the outputs show right now.
  logic [31:0] m_v0, m_v1;
  logic        m_was_en0, m_was_en1;
  logic        m_m0, m_m1;
  logic [1:0]  m_st;
  logic        m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One counter's next value from the behavioural rules.
  function automatic logic [31:0] next_count(input logic en, input logic was_en,
                                             input logic tick, input logic hit,
                                             input logic reload, input logic up,
                                             input logic [31:0] cur, input logic [31:0] load);
    if (!en)            return cur;
    if (!was_en)        return load;
    if (!tick)          return cur;
    if (hit && reload)  return load;
    return up ? cur + 32'd1 : cur - 32'd1;
  endfunction

  // Advance the model by one clock edge and queue the expected outputs.
  task automatic model_step();
    exp_t e;
    logic hit0, hit1, tick1;
    logic [1:0] st_n;
    if (!rst_n) begin
      m_v0 = '0; m_v1 = '0; m_was_en0 = 1'b0; m_was_en1 = 1'b0;
      m_m0 = 1'b0; m_m1 = 1'b0; m_st = 2'b00; m_irq = 1'b0;
    end else begin
      hit0  = cnt0_en && m_was_en0 && (m_v0 == cnt0_cmp);
      tick1 = cnt1_src ? hit0 : 1'b1;
      hit1  = cnt1_en && m_was_en1 && tick1 && (m_v1 == cnt1_cmp);
      st_n  = {m_m1, m_m0} | (m_st & ~irq_clr);
      m_irq = (m_st != 2'b00);
      m_st  = st_n;
      m_v0  = next_count(cnt0_en, m_was_en0, 1'b1, hit0, cnt0_reload, cnt0_count_up, m_v0, cnt0_load);
      m_v1  = next_count(cnt1_en, m_was_en1, tick1, hit1, cnt1_reload, cnt1_count_up, m_v1, cnt1_load);
      m_m0  = hit0;
      m_m1  = hit1;
      m_was_en0 = cnt0_en;
      m_was_en1 = cnt1_en;
    end
    e.v0 = m_v0; e.m0 = m_m0; e.v1 = m_v1; e.m1 = m_m1; e.st = m_st; e.irq = m_irq;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 7));
      2:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare each DUT output set against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cnt0_value", cnt0_value, e.v0);
        check("cnt0_match", {31'd0, cnt0_match}, {31'd0, e.m0});
        check("cnt1_value", cnt1_value, e.v1);
        check("cnt1_match", {31'd0, cnt1_match}, {31'd0, e.m1});
`ifdef TIMER_CORE_IRQ_EN
        check("irq_status", {30'd0, irq_status}, {30'd0, e.st});
        check("irq", {31'd0, irq}, {31'd0, e.irq});
`endif
      end
    end
  end

  // Stimulus.
  initial begin
    rst_n = 1'b0;
    cnt0_en = 0; cnt0_reload = 0; cnt0_count_up = 1; cnt0_load = 0; cnt0_cmp = 0;
    cnt1_en = 0; cnt1_reload = 0; cnt1_count_up = 1; cnt1_src = 0; cnt1_load = 0; cnt1_cmp = 0;
    irq_clr = 2'b00;
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Up-count with reload: 5,6,7,8,5,...
    cnt0_load = 32'd5; cnt0_cmp = 32'd8; cnt0_count_up = 1; cnt0_reload = 1; cnt0_en = 1;
    tick(12);

    // Down-count free-run wrap through zero.
    cnt0_en = 0;
    tick(1);
    cnt0_load = 32'd1; cnt0_cmp = 32'hFFFF_FFFE; cnt0_count_up = 0; cnt0_reload = 0; cnt0_en = 1;
    tick(7);

    // Cascade: counter1 steps on counter0 matches.
    cnt0_en = 0; cnt1_en = 0;
    tick(1);
    cnt0_load = 0; cnt0_cmp = 3; cnt0_count_up = 1; cnt0_reload = 1;
    cnt1_load = 0; cnt1_cmp = 2; cnt1_count_up = 1; cnt1_reload = 1; cnt1_src = 1;
    cnt0_en = 1; cnt1_en = 1;
    tick(40);

    // Enable gating and re-enable on counter1.
    cnt0_en = 0; cnt1_en = 0;
    tick(1);
    cnt1_src = 0; cnt1_load = 0; cnt1_cmp = 1000; cnt1_reload = 0; cnt1_en = 1;
    tick(11);
    cnt1_en = 0;
    tick(3);
    cnt1_en = 1;
    tick(4);

    // Reset mid-run with enable held high.
    cnt1_en = 0;
    cnt0_load = 0; cnt0_cmp = 100; cnt0_count_up = 1; cnt0_reload = 1; cnt0_en = 1;
    tick(8);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);

    // Match every tick; clear requested alongside each new match.
    cnt0_load = 3; cnt0_cmp = 3; cnt0_reload = 1;
    tick(4);
    irq_clr = 2'b01;
    tick(4);
    cnt0_en = 0;
    tick(3);
    irq_clr = 2'b00;
    tick(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) cnt0_en = ~cnt0_en;
      if ($urandom_range(0, 15) == 0) cnt1_en = ~cnt1_en;
      if ($urandom_range(0, 31) == 0) begin
        cnt0_reload = 1'($urandom); cnt0_count_up = 1'($urandom);
        cnt0_load = pick_val(); cnt0_cmp = pick_val();
      end
      if ($urandom_range(0, 31) == 0) begin
        cnt1_reload = 1'($urandom); cnt1_count_up = 1'($urandom); cnt1_src = 1'($urandom);
        cnt1_load = pick_val(); cnt1_cmp = pick_val();
      end
      if ($urandom_range(0, 31) == 0) cnt0_cmp = cnt0_value + 32'($urandom_range(0, 4));
      irq_clr = 2'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst_n = 1'b1;

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
